// File: rtl/posit_sched_pkg.sv
// Shared types and constants for the posit multiplier scheduler.
package posit_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONFIG = 3'd1,
    SHIFT  = 3'd2,
    WAIT   = 3'd3,
    HOLD   = 3'd4
  } state_e;

  // Smallest posit weight precision the multiplier supports.
  localparam int unsigned PREC_MIN  = 2;
  // Width of the precision field on the job and multiplier interfaces.
  localparam int unsigned PREC_W    = 4;
  // Guard bits the multiplier appends to the activation mantissa.
  localparam int unsigned MAN_GUARD = 4;
  // Result widths for the default FP16 configuration.
  localparam int unsigned RES_EXP_W = 5;
  localparam int unsigned RES_MAN_W = 10 + MAN_GUARD;

endpackage

// File: rtl/posit_w_serializer.sv
// Posit weight serializer: left-aligns a P-bit weight on load and emits it
// MSB first, one bit per shift, with a flag on the final bit.
module posit_w_serializer
  import posit_sched_pkg::*;
#(
  parameter int MAX_PREC = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic [MAX_PREC-1:0] weight,
  input  logic [PREC_W-1:0]   prec,
  output logic                bit_out,
  output logic                last
);

  logic [MAX_PREC-1:0] sr_q, sr_d;
  logic [PREC_W-1:0]   cnt_q, cnt_d;
  logic [PREC_W-1:0]   shamt;

  // Moves weight bit P-1 into the register MSB so output is always sr_q[MSB].
  assign shamt   = PREC_W'(MAX_PREC) - prec;
  assign bit_out = sr_q[MAX_PREC-1];
  assign last    = (cnt_q == '0);

  // Load/shift next-state; the bit counter runs down to zero on the last bit.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = weight << shamt;
      cnt_d = prec - PREC_W'(1);
    end else if (shift) begin
      sr_d = sr_q << 1;
      if (cnt_q != '0) cnt_d = cnt_q - PREC_W'(1);
    end
  end

  // Shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/posit_mul_sched.sv
// Posit multiplier job scheduler: accepts an activation/weight job, reprograms
// the multiplier precision when it changes, streams the weight bit-serially
// and holds the multiplier result until the consumer takes it.
// Optional build macro POSIT_SCHED_TIMEOUT_EN bounds the wait for mul_done.
//
//   state  | meaning
//   IDLE   | in_ready=1, waiting for a job
//   CONFIG | one-cycle mul_set pulse with the new precision
//   SHIFT  | P cycles of mul_valid, weight MSB first
//   WAIT   | weight sent, waiting for mul_done
//   HOLD   | out_valid=1 until out_ready
module posit_mul_sched
  import posit_sched_pkg::*;
#(
  parameter int ACT_WIDTH = 16,
  parameter int EXP_WIDTH = 5,
  parameter int MAN_WIDTH = 10,
  parameter int MAX_PREC  = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACT_WIDTH-1:0] in_act,
  input  logic [MAX_PREC-1:0]  in_weight,
  input  logic [3:0]           in_prec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic [MAN_WIDTH+3:0] out_man,
  output logic                 out_zero,
  output logic                 out_nar,
  output logic                 out_err,
  output logic [ACT_WIDTH-1:0] mul_act,
  output logic                 mul_w,
  output logic                 mul_valid,
  output logic                 mul_set,
  output logic [3:0]           mul_precision,
  input  logic                 mul_sign_out,
  input  logic [EXP_WIDTH-1:0] mul_exp_out,
  input  logic [MAN_WIDTH+3:0] mul_mantissa_out,
  input  logic                 mul_done,
  input  logic                 mul_zero,
  input  logic                 mul_nar
);

  state_e state_q, state_d;
  logic [ACT_WIDTH-1:0] act_q, act_d;
  logic [3:0]           prec_q, prec_d;
  logic [3:0]           cur_prec_q, cur_prec_d;
  logic                 sign_q, sign_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [MAN_WIDTH+3:0] man_q, man_d;
  logic                 zero_q, zero_d;
  logic                 nar_q, nar_d;
  logic                 err_q, err_d;
  logic                 prec_ok;
  logic                 ser_load, ser_shift, ser_bit, ser_last;

`ifdef POSIT_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign prec_ok = (in_prec >= 4'(PREC_MIN)) && (in_prec <= 4'(MAX_PREC));

  posit_w_serializer #(.MAX_PREC(MAX_PREC)) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (ser_load),
    .shift   (ser_shift),
    .weight  (in_weight),
    .prec    (in_prec),
    .bit_out (ser_bit),
    .last    (ser_last)
  );

  // Next-state, multiplier strobes and result capture.
  always_comb begin
    state_d       = state_q;
    act_d         = act_q;
    prec_d        = prec_q;
    cur_prec_d    = cur_prec_q;
    sign_d        = sign_q;
    exp_d         = exp_q;
    man_d         = man_q;
    zero_d        = zero_q;
    nar_d         = nar_q;
    err_d         = err_q;
    ser_load      = 1'b0;
    ser_shift     = 1'b0;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    mul_valid     = 1'b0;
    mul_set       = 1'b0;
    mul_w         = 1'b0;
    mul_precision = cur_prec_q;
`ifdef POSIT_SCHED_TIMEOUT_EN
    tmo_d         = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          act_d  = in_act;
          prec_d = in_prec;
          if (!prec_ok) begin
            sign_d  = 1'b0;
            exp_d   = '0;
            man_d   = '0;
            zero_d  = 1'b0;
            nar_d   = 1'b0;
            err_d   = 1'b1;
            state_d = HOLD;
          end else begin
            ser_load = 1'b1;
            state_d  = (in_prec != cur_prec_q) ? CONFIG : SHIFT;
          end
        end
      end
      CONFIG: begin
        mul_set       = 1'b1;
        mul_precision = prec_q;
        cur_prec_d    = prec_q;
        state_d       = SHIFT;
      end
      SHIFT, WAIT: begin
        if (state_q == SHIFT) begin
          mul_valid = 1'b1;
          mul_w     = ser_bit;
          ser_shift = 1'b1;
        end
        // Done is only meaningful once the whole weight has been sent.
        if (mul_done && (state_q == WAIT || ser_last)) begin
          sign_d  = mul_sign_out;
          exp_d   = mul_exp_out;
          man_d   = mul_mantissa_out;
          zero_d  = mul_zero;
          nar_d   = mul_nar;
          err_d   = 1'b0;
          state_d = HOLD;
        end else if (state_q == SHIFT) begin
          if (ser_last) begin
            state_d = WAIT;
`ifdef POSIT_SCHED_TIMEOUT_EN
            tmo_d   = TMO_W'(TIMEOUT - 1);
`endif
          end
        end else begin
`ifdef POSIT_SCHED_TIMEOUT_EN
          if (tmo_q == '0) begin
            // Multiplier state is unknown after a timeout, so force a reprogram.
            sign_d     = 1'b0;
            exp_d      = '0;
            man_d      = '0;
            zero_d     = 1'b0;
            nar_d      = 1'b0;
            err_d      = 1'b1;
            cur_prec_d = '0;
            state_d    = HOLD;
          end else begin
            tmo_d = tmo_q - TMO_W'(1);
          end
`endif
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, job and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      act_q      <= '0;
      prec_q     <= '0;
      cur_prec_q <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      man_q      <= '0;
      zero_q     <= 1'b0;
      nar_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef POSIT_SCHED_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      prec_q     <= prec_d;
      cur_prec_q <= cur_prec_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      man_q      <= man_d;
      zero_q     <= zero_d;
      nar_q      <= nar_d;
      err_q      <= err_d;
`ifdef POSIT_SCHED_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign mul_act  = act_q;
  assign out_sign = sign_q;
  assign out_exp  = exp_q;
  assign out_man  = man_q;
  assign out_zero = zero_q;
  assign out_nar  = nar_q;
  assign out_err  = err_q;

endmodule

// File: tb/tb_posit_mul_sched.sv
// Directed bench for posit_mul_sched; the multiplier side is driven by hand.
module tb_posit_mul_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_act;
  logic [7:0]  in_weight;
  logic [3:0]  in_prec;
  logic        out_valid, out_ready;
  logic        out_sign, out_zero, out_nar, out_err;
  logic [4:0]  out_exp;
  logic [13:0] out_man;
  logic [15:0] mul_act;
  logic        mul_w, mul_valid, mul_set;
  logic [3:0]  mul_precision;
  logic        mul_sign_out, mul_done, mul_zero, mul_nar;
  logic [4:0]  mul_exp_out;
  logic [13:0] mul_mantissa_out;

  int n_chk = 0;
  int n_bad = 0;

  logic       e_sign, e_zero, e_nar, e_err;
  logic [4:0] e_exp;
  logic [13:0] e_man;

  always #5 clk = ~clk;

  posit_mul_sched dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_act           (in_act),
    .in_weight        (in_weight),
    .in_prec          (in_prec),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_sign         (out_sign),
    .out_exp          (out_exp),
    .out_man          (out_man),
    .out_zero         (out_zero),
    .out_nar          (out_nar),
    .out_err          (out_err),
    .mul_act          (mul_act),
    .mul_w            (mul_w),
    .mul_valid        (mul_valid),
    .mul_set          (mul_set),
    .mul_precision    (mul_precision),
    .mul_sign_out     (mul_sign_out),
    .mul_exp_out      (mul_exp_out),
    .mul_mantissa_out (mul_mantissa_out),
    .mul_done         (mul_done),
    .mul_zero         (mul_zero),
    .mul_nar          (mul_nar)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_ovalid"}, 32'(out_valid), 1);
    chk({tag, "_iready"}, 32'(in_ready), 0);
    chk({tag, "_sign"}, 32'(out_sign), 32'(e_sign));
    chk({tag, "_exp"}, 32'(out_exp), 32'(e_exp));
    chk({tag, "_man"}, 32'(out_man), 32'(e_man));
    chk({tag, "_zero"}, 32'(out_zero), 32'(e_zero));
    chk({tag, "_nar"}, 32'(out_nar), 32'(e_nar));
    chk({tag, "_err"}, 32'(out_err), 32'(e_err));
  endtask

  task automatic hold_release(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_result("hold");
      chk("hold_mvalid", 32'(mul_valid), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("rel_ovalid", 32'(out_valid), 0);
    chk("rel_iready", 32'(in_ready), 1);
  endtask

  task automatic do_job(input logic [15:0] act, input logic [7:0] w, input int p,
                        input bit cfg, input int lat, input logic rs, input logic [4:0] re,
                        input logic [13:0] rm, input logic rz, input logic rn);
    chk("acc_iready", 32'(in_ready), 1);
    in_valid  = 1'b1;
    in_act    = act;
    in_weight = w;
    in_prec   = 4'(p);
    @(negedge clk);
    in_valid  = 1'b0;
    in_act    = 16'hDEAD;
    in_weight = 8'hFF;
    in_prec   = 4'd5;
    if (cfg) begin
      chk("cfg_set", 32'(mul_set), 1);
      chk("cfg_prec", 32'(mul_precision), 32'(p));
      chk("cfg_mvalid", 32'(mul_valid), 0);
      @(negedge clk);
    end
    for (int k = 0; k < p; k++) begin
      chk("sh_mvalid", 32'(mul_valid), 1);
      chk("sh_set", 32'(mul_set), 0);
      chk("sh_w", 32'(mul_w), 32'(w[p-1-k]));
      chk("sh_act", 32'(mul_act), 32'(act));
      chk("sh_ovalid", 32'(out_valid), 0);
      if (k == p - 1 && lat == 0) begin
        mul_done = 1'b1; mul_sign_out = rs; mul_exp_out = re;
        mul_mantissa_out = rm; mul_zero = rz; mul_nar = rn;
      end
      @(negedge clk);
    end
    for (int j = 1; j <= lat; j++) begin
      chk("wt_mvalid", 32'(mul_valid), 0);
      chk("wt_ovalid", 32'(out_valid), 0);
      if (j == lat) begin
        mul_done = 1'b1; mul_sign_out = rs; mul_exp_out = re;
        mul_mantissa_out = rm; mul_zero = rz; mul_nar = rn;
      end
      @(negedge clk);
    end
    mul_done = 1'b0;
    mul_sign_out = ~rs; mul_exp_out = ~re; mul_mantissa_out = ~rm;
    mul_zero = ~rz; mul_nar = ~rn;
    e_sign = rs; e_exp = re; e_man = rm; e_zero = rz; e_nar = rn; e_err = 1'b0;
    check_result("res");
    chk("res_act", 32'(mul_act), 32'(act));
  endtask

  task automatic do_illegal(input int p);
    in_valid  = 1'b1;
    in_act    = 16'h7777;
    in_weight = 8'hFF;
    in_prec   = 4'(p);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ill_mvalid", 32'(mul_valid), 0);
    chk("ill_set", 32'(mul_set), 0);
    e_sign = 0; e_exp = '0; e_man = '0; e_zero = 0; e_nar = 0; e_err = 1;
    check_result("ill");
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_act = '0; in_weight = '0; in_prec = '0; out_ready = 0;
    mul_sign_out = 0; mul_exp_out = '0; mul_mantissa_out = '0;
    mul_done = 0; mul_zero = 0; mul_nar = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_iready", 32'(in_ready), 1);
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_mvalid", 32'(mul_valid), 0);
    chk("rst_set", 32'(mul_set), 0);
    chk("rst_err", 32'(out_err), 0);
    chk("rst_prec", 32'(mul_precision), 0);

    // New precision, done on the last bit.
    do_job(16'h1234, 8'h0A, 4, 1, 0, 1'b1, 5'h0F, 14'h2ABC, 1'b0, 1'b0);
    hold_release(0);
    // Same precision: no reconfigure, done two cycles after the last bit.
    do_job(16'hABCD, 8'h06, 4, 0, 2, 1'b0, 5'h11, 14'h1357, 1'b0, 1'b1);
    hold_release(5);

    // A stray done while idle must not disturb anything.
    mul_done = 1'b1; mul_sign_out = 1'b1; mul_exp_out = 5'h1E;
    @(negedge clk);
    mul_done = 1'b0;
    chk("idle_done_ovalid", 32'(out_valid), 0);
    chk("idle_done_iready", 32'(in_ready), 1);
    chk("idle_done_exp", 32'(out_exp), 32'h11);

    do_illegal(9);
    hold_release(1);
    do_illegal(1);
    hold_release(0);
    do_job(16'h0F0F, 8'h05, 3, 1, 1, 1'b1, 5'h03, 14'h0001, 1'b1, 1'b0);
    hold_release(0);

    // Reset during the third SHIFT bit.
    in_valid = 1'b1; in_act = 16'h5555; in_weight = 8'h0C; in_prec = 4'd4;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ri_set", 32'(mul_set), 1);
    repeat (3) @(negedge clk);
    chk("ri_mvalid", 32'(mul_valid), 1);
    chk("ri_w2", 32'(mul_w), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ri_iready", 32'(in_ready), 1);
    chk("ri_mvalid0", 32'(mul_valid), 0);
    chk("ri_ovalid", 32'(out_valid), 0);
    chk("ri_sign", 32'(out_sign), 0);
    chk("ri_zero", 32'(out_zero), 0);
    chk("ri_act", 32'(mul_act), 0);
    do_job(16'h4242, 8'h09, 4, 1, 3, 1'b0, 5'h1F, 14'h3FFF, 1'b0, 1'b0);
    hold_release(0);

    // Precision boundaries.
    do_job(16'h8001, 8'hB5, 8, 1, 0, 1'b1, 5'h00, 14'h0000, 1'b0, 1'b1);
    hold_release(0);
    do_job(16'h1111, 8'h02, 2, 1, 0, 1'b0, 5'h0A, 14'h0555, 1'b0, 1'b0);
    hold_release(0);

`ifdef POSIT_SCHED_TIMEOUT_EN
    begin
      int n;
      in_valid = 1'b1; in_act = 16'h2222; in_weight = 8'h01; in_prec = 4'd2;
      @(negedge clk);
      in_valid = 1'b0;
      chk("to_noset", 32'(mul_set), 0);
      repeat (2) @(negedge clk);
      n = 0;
      for (int i = 0; i < 200; i++) begin
        if (out_valid) break;
        n++;
        @(negedge clk);
      end
      chk("to_wait_cycles", 32'(n), 64);
      e_sign = 0; e_exp = '0; e_man = '0; e_zero = 0; e_nar = 0; e_err = 1;
      check_result("to");
      hold_release(0);
      do_job(16'h3333, 8'h03, 2, 1, 0, 1'b1, 5'h01, 14'h0002, 1'b0, 1'b0);
      hold_release(0);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/posit_mul_sched.md
POSIT_MUL_SCHED -- requirements
Module: posit_mul_sched

Interface
REQ-001 SHALL have parameter ACT_WIDTH, default 16, FP16 activation width.
REQ-002 SHALL have parameter EXP_WIDTH, default 5, result exponent width.
REQ-003 SHALL have parameter MAN_WIDTH, default 10, activation mantissa width; result mantissa is MAN_WIDTH+4 bits.
REQ-004 SHALL have parameter MAX_PREC, default 8, maximum posit weight precision in bits.
REQ-005 SHALL have parameter TIMEOUT, default 64, done-wait limit in cycles.
REQ-006 SHALL have port clk  in  1  sole clock; all logic on the rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports in_valid in 1, in_ready out 1: job handshake.
REQ-009 SHALL have ports in_act in ACT_WIDTH, in_weight in MAX_PREC (LSB-aligned), in_prec in 4: job payload.
REQ-010 SHALL have ports out_valid out 1, out_ready in 1: result handshake.
REQ-011 SHALL have ports out_sign out 1, out_exp out EXP_WIDTH, out_man out MAN_WIDTH+4, out_zero out 1, out_nar out 1, out_err out 1: result.
REQ-012 SHALL have multiplier-side outputs mul_act ACT_WIDTH, mul_w 1, mul_valid 1, mul_set 1, mul_precision 4.
REQ-013 SHALL have multiplier-side inputs mul_sign_out 1, mul_exp_out EXP_WIDTH, mul_mantissa_out MAN_WIDTH+4, mul_done 1, mul_zero 1, mul_nar 1.

Function
REQ-014 FSM states SHALL be IDLE, CONFIG, SHIFT, WAIT, HOLD; in_ready SHALL be 1 only in IDLE.
REQ-015 Accept (in_valid&&in_ready) SHALL register in_act, in_weight, in_prec; mul_act SHALL hold the registered activation until HOLD exits.
REQ-016 Legal precision is 2..MAX_PREC; an illegal in_prec SHALL go IDLE->HOLD directly with out_err=1, all other result fields 0, no mul_valid/mul_set activity.
REQ-017 If legal in_prec differs from the configured precision register cur_prec, next state SHALL be CONFIG, else SHIFT.
REQ-018 CONFIG SHALL last exactly one cycle driving mul_set=1, mul_precision=job precision, mul_valid=0, and update cur_prec.
REQ-019 SHIFT SHALL last exactly P=prec cycles with mul_valid=1, mul_w=in_weight[P-1-k] in cycle k (MSB first), then go WAIT.
REQ-020 WAIT SHALL drive mul_valid=0 and hold until mul_done; mul_done SHALL also be honoured in the last SHIFT cycle (skip WAIT).
REQ-021 The first mul_done in SHIFT/WAIT SHALL capture all six result fields into output registers with out_err=0 and enter HOLD; mul_done in IDLE/CONFIG/HOLD SHALL be ignored.
REQ-022 HOLD SHALL assert out_valid with stable outputs until out_ready; on out_valid&&out_ready next state SHALL be IDLE (no same-cycle accept).
REQ-023 Job latency accept->out_valid SHALL be 1 + (1 if CONFIG) + P + L cycles, L = multiplier done latency after last bit.
REQ-024 mul_set and mul_valid SHALL never be asserted in the same cycle.

Reset
REQ-025 rst SHALL, at any state including mid-SHIFT, return to IDLE, set cur_prec=0 (unconfigured), and zero all outputs except in_ready, which SHALL be 1 after the reset cycle.

Configuration
REQ-026 With POSIT_SCHED_TIMEOUT_EN defined, a counter SHALL run in WAIT; at TIMEOUT cycles without mul_done the FSM SHALL enter HOLD with out_err=1, other result fields 0, and cur_prec cleared to 0 to force reconfiguration.
REQ-027 Without POSIT_SCHED_TIMEOUT_EN, WAIT SHALL be unbounded and out_err SHALL be driven only by REQ-016.

Structure
REQ-028 Package posit_sched_pkg SHALL hold the state enum, PREC_MIN=2, and result-width localparams.
REQ-029 Weight serialization SHALL be sub-module posit_w_serializer (load, shift register, bit counter, last flag).

Verification
REQ-030 Reset, job act=16'h1234, weight=4'b1010, prec=4 -> one mul_set pulse, then mul_w 1,0,1,0 with mul_valid=1 for 4 cycles; model done captured to out_*.
REQ-031 Second job same prec=4, weight=4'b0110 -> no mul_set, SHIFT begins cycle after accept, mul_w 0,1,1,0.
REQ-032 Result pending, out_ready low 5 cycles -> out_valid and all out_* stable, in_ready=0 throughout.
REQ-033 Job prec=9 -> no mul activity, out_valid next cycle with out_err=1; prec=3 afterwards -> mul_set with mul_precision=3.
REQ-034 rst pulsed during SHIFT bit 2 -> next cycle IDLE, mul_valid=0, in_ready=1; following prec=4 job issues mul_set.
REQ-035 With POSIT_SCHED_TIMEOUT_EN, TIMEOUT=64, mul_done never -> out_valid with out_err=1 after 64 WAIT cycles; next job re-issues mul_set.
